// File: rtl/lsu_sram_bridge_if.sv
// CPU-side load/store request/response bus of the LSU-to-SRAM bridge.
//   req_valid/req_ready  : request handshake (accept when both high)
//   req_we               : 1 = store, 0 = load
//   req_addr             : byte address
//   req_wdata            : store data, right-aligned
//   req_size             : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned         : load zero-extend (1) or sign-extend (0)
//   rsp_valid            : one-cycle response strobe
//   rsp_rdata            : extended load data (0 for stores and errors)
//   rsp_err              : fault or timeout flag
// Modports: master = CPU/LSU side, slave = bridge side.
interface lsu_sram_bridge_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_sram_bridge.sv
// Load/store adapter in front of the 32-bit IS61WV25616 SRAM controller.
// Takes one byte/half/word request at a time, checks alignment and the
// 512 KB address window, issues a single-cycle read or write pulse with a
// byte-lane mask and lane-replicated write data, waits for the controller
// ack (bounded by TIMEOUT_CYCLES) and returns a one-cycle response.
// Ports:
//   i_clk, i_reset       : clock, synchronous active-low reset
//   cpu                  : CPU request/response bus (slave modport)
//   o_sram_addr          : 16-bit-word address, bit0 always 0
//   o_sram_wdata         : lane-replicated write data
//   o_sram_bmask         : byte-lane mask for reads and writes
//   o_sram_wren/rden     : one-cycle write/read pulses
//   i_sram_rdata         : controller read data, valid with ack
//   i_sram_ack           : controller completion
module lsu_sram_bridge #(
  parameter logic [31:0] BASE_ADDR      = 32'h0008_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  lsu_sram_bridge_if.slave    cpu,
  output logic [17:0]         o_sram_addr,
  output logic [31:0]         o_sram_wdata,
  output logic [3:0]          o_sram_bmask,
  output logic                o_sram_wren,
  output logic                o_sram_rden,
  input  logic [31:0]         i_sram_rdata,
  input  logic                i_sram_ack
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic        req_we;
  logic [18:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_uns;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic [CW-1:0] tmo_cnt;

  logic        fault;
  logic        tmo_hit;
  logic [31:0] rd_shift;
  logic [31:0] load_ext;
  logic [3:0]  lane_mask;
  logic [31:0] lane_wdata;

  // Request fault check on the live inputs (only meaningful when accepting).
  always_comb begin
    fault = 1'b0;
    case (cpu.req_size)
      2'b00:   fault = 1'b0;
      2'b01:   fault = cpu.req_addr[0];
      2'b10:   fault = |cpu.req_addr[1:0];
      default: fault = 1'b1;
    endcase
    if (cpu.req_addr[31:19] != BASE_ADDR[31:19]) fault = 1'b1;
  end

  assign tmo_hit = (tmo_cnt == TMO_LAST);

  // Accepted requests are naturally aligned, so shifting by the byte offset
  // brings the addressed lane to bit 0 for every size.
  assign rd_shift = i_sram_rdata >> {req_addr[1:0], 3'b000};

  always_comb begin
    load_ext = '0;
    case (req_size)
      2'b00:   load_ext = {{24{~req_uns & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_ext = {{16{~req_uns & rd_shift[15]}}, rd_shift[15:0]};
      default: load_ext = rd_shift;
    endcase
  end

  always_comb begin
    lane_mask  = '0;
    lane_wdata = '0;
    case (req_size)
      2'b00: begin
        lane_mask  = 4'b0001 << req_addr[1:0];
        lane_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        lane_mask  = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        lane_mask  = 4'b1111;
        lane_wdata = req_wdata;
      end
      default: begin
        lane_mask  = '0;
        lane_wdata = '0;
      end
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cpu.req_valid) state_nxt = fault ? S_RESP : S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (i_sram_ack || tmo_hit) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request capture, timeout counter and response registers
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      req_we      <= 1'b0;
      req_addr    <= '0;
      req_wdata   <= '0;
      req_size    <= '0;
      req_uns     <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu.req_valid) begin
            req_we      <= cpu.req_we;
            req_addr    <= cpu.req_addr[18:0];
            req_wdata   <= cpu.req_wdata;
            req_size    <= cpu.req_size;
            req_uns     <= cpu.req_unsigned;
            rsp_rdata_q <= '0;
            rsp_err_q   <= fault;
          end
        end
        S_ISSUE: tmo_cnt <= '0;
        S_WAIT: begin
          if (i_sram_ack) begin
            rsp_rdata_q <= req_we ? '0 : load_ext;
            rsp_err_q   <= 1'b0;
          end else if (tmo_hit) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_RESP: begin
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Outputs: everything forced to 0 outside the states that own it
  always_comb begin
    cpu.req_ready = 1'b0;
    cpu.rsp_valid = 1'b0;
    cpu.rsp_rdata = '0;
    cpu.rsp_err   = 1'b0;
    o_sram_addr   = '0;
    o_sram_wdata  = '0;
    o_sram_bmask  = '0;
    o_sram_wren   = 1'b0;
    o_sram_rden   = 1'b0;
    case (state)
      S_IDLE: cpu.req_ready = 1'b1;
      S_ISSUE: begin
        o_sram_addr  = {req_addr[18:2], 1'b0};
        o_sram_wdata = lane_wdata;
        o_sram_bmask = lane_mask;
        o_sram_wren  = req_we;
        o_sram_rden  = ~req_we;
      end
      S_WAIT: begin
        o_sram_addr  = {req_addr[18:2], 1'b0};
        o_sram_wdata = lane_wdata;
        o_sram_bmask = lane_mask;
      end
      S_RESP: begin
        cpu.rsp_valid = 1'b1;
        cpu.rsp_rdata = rsp_rdata_q;
        cpu.rsp_err   = rsp_err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_sram_bridge.sv
// Self-checking bench for lsu_sram_bridge: directed scenarios followed by
// randomized requests, compared against a byte-level reference model with
// a small SRAM image kept in the bench.
module tb_lsu_sram_bridge;

  localparam logic [31:0] BASE = 32'h0008_0000;
  localparam int          TMO  = 16;

  logic        clk;
  logic        rst_n;
  logic [17:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [3:0]  sram_bmask;
  logic        sram_wren;
  logic        sram_rden;
  logic [31:0] sram_rdata;
  logic        sram_ack;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [int];

  lsu_sram_bridge_if bus ();

  lsu_sram_bridge #(
    .BASE_ADDR      (BASE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .cpu          (bus),
    .o_sram_addr  (sram_addr),
    .o_sram_wdata (sram_wdata),
    .o_sram_bmask (sram_bmask),
    .o_sram_wren  (sram_wren),
    .o_sram_rden  (sram_rden),
    .i_sram_rdata (sram_rdata),
    .i_sram_ack   (sram_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_fault(input logic [31:0] addr, input logic [1:0] sz);
    if (sz == 2'd3) return 1'b1;
    if ((addr % (32'd1 << sz)) != 0) return 1'b1;
    if ((addr / 32'h0008_0000) != (BASE / 32'h0008_0000)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_mask(input logic [31:0] addr, input logic [1:0] sz);
    int nb;
    nb = 1 << sz;
    return 4'(((1 << nb) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [1:0] sz);
    logic [31:0] r;
    int nb;
    nb = 1 << sz;
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [17:0] model_saddr(input logic [31:0] addr);
    return 18'(((addr % 32'h0008_0000) / 4) * 2);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [1:0] sz, input logic uns);
    int nb;
    logic [31:0] m, v;
    nb = 1 << sz;
    m = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
    v = (word >> (8*(addr % 4))) & m;
    if (!uns && v[8*nb-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    int idx;
    idx = int'((addr % 32'h0008_0000) / 4);
    if (!mem.exists(idx)) mem[idx] = $urandom;
    return mem[idx];
  endfunction

  task automatic mem_store(input logic [31:0] addr, input logic [3:0] m, input logic [31:0] d);
    logic [31:0] w;
    w = mem_word(addr);
    for (int i = 0; i < 4; i++) if (m[i]) w[8*i +: 8] = d[8*i +: 8];
    mem[int'((addr % 32'h0008_0000) / 4)] = w;
  endtask

  // One request; ack_dly = cycles after the pulse at which ack is raised
  // (0 = never ack, expect timeout). Inputs are driven/sampled 1 after posedge.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] sz, input logic uns, input int ack_dly,
                         input logic [31:0] ack_word);
    bit flt;
    int cyc;
    logic [3:0]  emask;
    logic [31:0] ewd;
    flt   = model_fault(addr, sz);
    emask = model_mask(addr, sz);
    ewd   = model_wdata(wd, sz);
    check("ready_idle", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    @(posedge clk); #1;
    cyc = 1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'($urandom);
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = 1'($urandom);
    if (flt) begin
      check("flt_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("flt_err",   {31'd0, bus.rsp_err},   32'd1);
      check("flt_rdata", bus.rsp_rdata, 32'd0);
      check("flt_pulse", {30'd0, sram_wren, sram_rden}, 32'd0);
    end else begin
      check("iss_wren",  {31'd0, sram_wren}, {31'd0, we});
      check("iss_rden",  {31'd0, sram_rden}, {31'd0, ~we});
      check("iss_addr",  {14'd0, sram_addr}, {14'd0, model_saddr(addr)});
      check("iss_bmask", {28'd0, sram_bmask}, {28'd0, emask});
      if (we) check("iss_wdata", sram_wdata, ewd);
      if (ack_dly > 0) begin
        for (int d = 1; d <= ack_dly; d++) begin
          @(posedge clk); #1;
          cyc++;
          check("wait_quiet", {29'd0, sram_wren, sram_rden, bus.rsp_valid}, 32'd0);
          check("wait_bmask", {28'd0, sram_bmask}, {28'd0, emask});
          if (d == ack_dly) begin
            sram_ack   = 1'b1;
            sram_rdata = ack_word;
          end
        end
        @(posedge clk); #1;
        cyc++;
        sram_ack   = 1'b0;
        sram_rdata = $urandom;
        check("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("rsp_err",   {31'd0, bus.rsp_err},   32'd0);
        check("rsp_rdata", bus.rsp_rdata, we ? 32'd0 : model_load(ack_word, addr, sz, uns));
        check("latency",   cyc, ack_dly + 2);
        if (we) mem_store(addr, emask, ewd);
      end else begin
        for (int i = 0; i < TMO; i++) begin
          @(posedge clk); #1;
          if (bus.rsp_valid !== 1'b0) check("tmo_early", {31'd0, bus.rsp_valid}, 32'd0);
        end
        @(posedge clk); #1;
        check("tmo_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("tmo_err",   {31'd0, bus.rsp_err},   32'd1);
        check("tmo_rdata", bus.rsp_rdata, 32'd0);
      end
    end
    @(posedge clk); #1;
    check("post_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("post_rdata", bus.rsp_rdata, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        we, uns;
    logic [31:0] addr, wd;
    logic [1:0]  sz;
    int          dly;

    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_size = '0; bus.req_unsigned = 1'b0;
    sram_ack = 1'b0; sram_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_rsp",   {30'd0, bus.rsp_valid, bus.rsp_err}, 32'd0);
    check("rst_pulse", {28'd0, sram_bmask}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed scenarios
    run_txn(1'b1, 32'h0008_0010, 32'hDEAD_BEEF, 2'd2, 1'b0, 2, 32'h0);
    run_txn(1'b0, 32'h0008_0013, 32'h0, 2'd0, 1'b0, 3, 32'h80AA_BBCC);
    check("dir_byte_s", model_load(32'h80AA_BBCC, 32'h0008_0013, 2'd0, 1'b0), 32'hFFFF_FF80);
    run_txn(1'b0, 32'h0008_0013, 32'h0, 2'd0, 1'b1, 3, 32'h80AA_BBCC);
    run_txn(1'b1, 32'h0008_0002, 32'h0000_1234, 2'd1, 1'b0, 2, 32'h0);
    run_txn(1'b0, 32'h0008_0002, 32'h0, 2'd1, 1'b0, 3, 32'h8001_0000);
    run_txn(1'b0, 32'h0008_0002, 32'h0, 2'd2, 1'b0, 3, 32'h0);
    run_txn(1'b0, 32'h0008_0000, 32'h0, 2'd3, 1'b0, 3, 32'h0);
    run_txn(1'b0, 32'h0010_0000, 32'h0, 2'd2, 1'b0, 3, 32'h0);

    // Timeout, then a late ack that must be ignored
    run_txn(1'b0, 32'h0008_0020, 32'h0, 2'd2, 1'b0, 0, 32'h0);
    sram_ack = 1'b1; sram_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    sram_ack = 1'b0;
    check("late_ack_v", {31'd0, bus.rsp_valid}, 32'd0);
    @(posedge clk); #1;
    check("late_ack_v2", {31'd0, bus.rsp_valid}, 32'd0);
    check("late_ack_rdy", {31'd0, bus.req_ready}, 32'd1);
    run_txn(1'b0, 32'h0008_0024, 32'h0, 2'd2, 1'b1, 3, 32'hCAFE_F00D);

    // Reset during WAIT of a store
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h0008_0030;
    bus.req_wdata = 32'h5555_AAAA; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mrst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("mrst_outs",  {26'd0, sram_wren, sram_rden, sram_bmask}, 32'd0);
    check("mrst_addr",  {14'd0, sram_addr}, 32'd0);
    check("mrst_wdata", sram_wdata, 32'd0);
    check("mrst_rsp",   {30'd0, bus.rsp_valid, bus.rsp_err}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b0) check("mrst_norsp", {31'd0, bus.rsp_valid}, 32'd0);
    end
    run_txn(1'b0, 32'h0008_0034, 32'h0, 2'd2, 1'b0, 3, 32'h0BAD_C0DE);

    // Randomized traffic over a small region, loads read back the SRAM image
    for (int n = 0; n < 200; n++) begin
      we  = 1'($urandom);
      uns = 1'($urandom);
      wd  = $urandom;
      sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) addr = $urandom;
      else addr = BASE + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) addr = addr & ~((32'd1 << sz) - 32'd1);
      case ($urandom_range(0, 11))
        0:       dly = 0;
        1, 2:    dly = $urandom_range(1, 6);
        default: dly = we ? 2 : 3;
      endcase
      run_txn(we, addr, wd, sz, uns, dly, we ? $urandom : mem_word(addr));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
